btn_debounce: RTL

- Upstream conditioning stage for the board push-buttons on the Cmod A7 design.
- Takes raw, asynchronous, bouncing button pins and synchronises them to sysclk.
- Produces per-button debounced levels, one-cycle rise/fall pulses and a one-shot long-press pulse.
- The downstream LED flasher/counter logic consumes btn_q as its clear/control input in place of the raw pins.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 94 +++++++++
 rtl/btn_debounce.sv | 36 +++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default 12 MHz timing for the button conditioner
package btn_pkg;

   typedef enum logic [1:0] {
      LOW    = 2'd0,
      PEND_H = 2'd1,
      HIGH   = 2'd2,
      PEND_L = 2'd3
   } btn_state_t;

   localparam int DEF_N_BTN           = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 120000;
   localparam int DEF_LONG_CYCLES     = 12000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel - synchroniser, debounce FSM, long-press timer, pulses
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
)(
   input  logic sysclk,
   input  logic rst_n,
   input  logic btn,
   output logic btn_q,
   output logic rise_p,
   output logic fall_p,
   output logic long_p
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int LW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

   logic          s1, s2;
   btn_state_t    state;
   logic [DW-1:0] dcnt;
   logic [LW-1:0] lcnt;
   logic          long_done;

   // two-flop synchroniser for the asynchronous pin
   always_ff @(posedge sysclk or negedge rst_n)
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end

   // debounce FSM with long-press timer; timer survives rejected releases
   always_ff @(posedge sysclk or negedge rst_n)
      if (!rst_n) begin
         state     <= LOW;
         dcnt      <= '0;
         lcnt      <= '0;
         long_done <= 1'b0;
         btn_q     <= 1'b0;
         rise_p    <= 1'b0;
         fall_p    <= 1'b0;
         long_p    <= 1'b0;
      end else begin
         rise_p <= 1'b0;
         fall_p <= 1'b0;
         long_p <= btn_q && !long_done && lcnt == L_LAST;
         if (btn_q && !long_done) begin
            if (lcnt == L_LAST) long_done <= 1'b1;
            else lcnt <= lcnt + LW'(1);
         end
         case (state)
            LOW:
               if (s2) begin
                  state <= PEND_H;
                  dcnt  <= DW'(1);
               end
            PEND_H:
               if (!s2) begin
                  state <= LOW;
                  dcnt  <= '0;
               end else if (dcnt == D_LAST) begin
                  state  <= HIGH;
                  btn_q  <= 1'b1;
                  rise_p <= 1'b1;
                  dcnt   <= '0;
               end else dcnt <= dcnt + DW'(1);
            HIGH:
               if (!s2) begin
                  state <= PEND_L;
                  dcnt  <= DW'(1);
               end
            PEND_L:
               if (s2) begin
                  state <= HIGH;
                  dcnt  <= '0;
               end else if (dcnt == D_LAST) begin
                  state     <= LOW;
                  btn_q     <= 1'b0;
                  fall_p    <= 1'b1;
                  dcnt      <= '0;
                  lcnt      <= '0;
                  long_done <= 1'b0;
               end else dcnt <= dcnt + DW'(1);
            default: state <= LOW;
         endcase
      end

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: conditions N_BTN raw push-button pins into clean levels and event pulses
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_BTN           = DEF_N_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
)(
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] btn_q,
   output logic [N_BTN-1:0] rise_p,
   output logic [N_BTN-1:0] fall_p,
   output logic [N_BTN-1:0] long_p
);

   genvar i;
   generate
      for (i = 0; i < N_BTN; i++) begin : g_ch
         btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
         ) u_ch (
            .sysclk(sysclk),
            .rst_n (rst_n),
            .btn   (btn[i]),
            .btn_q (btn_q[i]),
            .rise_p(rise_p[i]),
            .fall_p(fall_p[i]),
            .long_p(long_p[i])
         );
      end
   endgenerate

endmodule
